// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and default operand width.
package restoring_divider_pkg;

  localparam int unsigned DEFAULT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/restoring_divider_if.sv
// Request/result bundle for the restoring divider; the requester drives master, the divider is slave.
interface restoring_divider_if
  import restoring_divider_pkg::*;
#(
  parameter int unsigned W = DEFAULT_W
);

  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/restoring_divider_sub.sv
// Ripple subtractor S = A + ~B + CI built from full-subtractor cells; CO=1 means no borrow.
module rc_subtractor_w
  import restoring_divider_pkg::*;
#(
  parameter int unsigned W = DEFAULT_W + 1
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         CI,
  output logic [W-1:0] S,
  output logic         CO
);

  logic [W:0] c;

  assign c[0] = CI;

  for (genvar i = 0; i < W; i++) begin : g_cell
    logic bn;
    assign bn       = ~B[i];
    assign S[i]     = A[i] ^ bn ^ c[i];
    assign c[i+1]   = (A[i] & bn) | (c[i] & (A[i] ^ bn));
  end

  assign CO = c[W];

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle restoring divider: one quotient bit per cycle, MSB first, with divide-by-zero bypass.
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int unsigned W = DEFAULT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  restoring_divider_if.slave  div_if
);

  localparam int unsigned CW = $clog2(W);

  state_e        state_q, state_d;
  logic [W-1:0]  n_q, n_d;
  logic [W-1:0]  d_q, d_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dbz_q, dbz_d;

  logic [W:0]    p;
  logic [W:0]    t;
  logic          co;
  logic          accept;
  logic          sub_msb_unused;

  assign p = {r_q, n_q[cnt_q]};

  rc_subtractor_w #(.W(W + 1)) u_sub (
    .A  (p),
    .B  ({1'b0, d_q}),
    .CI (1'b1),
    .S  (t),
    .CO (co)
  );

  // With P < 2D the difference always fits in W bits when there is no borrow.
  assign sub_msb_unused = t[W];

  assign accept = div_if.start && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    d_d     = d_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      RUN: begin
        q_d[cnt_q] = co;
        r_d        = co ? t[W-1:0] : p[W-1:0];
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: ;
    endcase

    if (accept) begin
      n_d   = div_if.dividend;
      d_d   = div_if.divisor;
      cnt_d = CW'(W - 1);
      if (div_if.divisor == '0) begin
        state_d = DONE;
        q_d     = '1;
        r_d     = div_if.dividend;
        dbz_d   = 1'b1;
      end else begin
        state_d = RUN;
        q_d     = '0;
        r_d     = '0;
        dbz_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      d_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      d_q     <= d_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  assign div_if.busy        = (state_q == RUN);
  assign div_if.done        = (state_q == DONE);
  assign div_if.quotient    = q_q;
  assign div_if.remainder   = r_q;
  assign div_if.div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider against a plain-arithmetic division model.
module tb_restoring_divider;
  import restoring_divider_pkg::*;

  localparam int unsigned W    = DEFAULT_W;
  localparam int unsigned MAXV = (1 << W) - 1;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;

  restoring_divider_if #(.W(W)) ifc ();

  restoring_divider #(.W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .div_if (ifc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned ref_q(input int unsigned n, input int unsigned d);
    return (d == 0) ? MAXV : n / d;
  endfunction

  function automatic int unsigned ref_r(input int unsigned n, input int unsigned d);
    return (d == 0) ? n : n % d;
  endfunction

  // Called #1 after the accepting edge; waits for done and checks latency and results.
  task automatic collect(input string tag, input int unsigned n, input int unsigned d);
    int unsigned edges;
    bit          busy_seen;
    edges     = 1;
    busy_seen = 1'b0;
    while (!ifc.done && edges < W + 8) begin
      if (ifc.busy) busy_seen = 1'b1;
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, "_done"}, 32'(ifc.done), 32'd1);
    check({tag, "_latency"}, edges, (d == 0) ? 32'd1 : W + 1);
    check({tag, "_q"}, 32'(ifc.quotient), ref_q(n, d));
    check({tag, "_r"}, 32'(ifc.remainder), ref_r(n, d));
    check({tag, "_dbz"}, 32'(ifc.div_by_zero), (d == 0) ? 32'd1 : 32'd0);
    if (d == 0) check({tag, "_busy"}, 32'(busy_seen), 32'd0);
  endtask

  task automatic run_div(input string tag, input int unsigned n, input int unsigned d);
    @(negedge clk);
    ifc.start    = 1'b1;
    ifc.dividend = n[W-1:0];
    ifc.divisor  = d[W-1:0];
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    collect(tag, n, d);
    @(posedge clk);
    #1;
    check({tag, "_hold_q"}, 32'(ifc.quotient), ref_q(n, d));
    check({tag, "_hold_done"}, 32'(ifc.done), 32'd0);
  endtask

  initial begin
    ifc.start    = 1'b0;
    ifc.dividend = '0;
    ifc.divisor  = '0;

    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_done", 32'(ifc.done), 32'd0);
    check("rst_q", 32'(ifc.quotient), 32'd0);
    check("rst_r", 32'(ifc.remainder), 32'd0);
    check("rst_dbz", 32'(ifc.div_by_zero), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_div("d6_1", 6, 1);
    run_div("d5_3", 5, 3);
    run_div("d4_6", 4, 6);
    run_div("d7_7", 7, 7);
    run_div("d7_0", 7, 0);

    // Start held through RUN with new operands, then accepted back-to-back in DONE.
    @(negedge clk);
    ifc.start    = 1'b1;
    ifc.dividend = W'(5);
    ifc.divisor  = W'(3);
    @(posedge clk);
    #1;
    ifc.dividend = W'(7);
    ifc.divisor  = W'(2);
    collect("held", 5, 3);
    @(posedge clk);
    #1;
    check("b2b_busy", 32'(ifc.busy), 32'd1);
    ifc.start = 1'b0;
    collect("b2b", 7, 2);

    // Reset two cycles into a division.
    @(negedge clk);
    ifc.start    = 1'b1;
    ifc.dividend = W'(6);
    ifc.divisor  = W'(1);
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(ifc.busy), 32'd0);
    check("mid_rst_done", 32'(ifc.done), 32'd0);
    check("mid_rst_q", 32'(ifc.quotient), 32'd0);
    check("mid_rst_r", 32'(ifc.remainder), 32'd0);
    check("mid_rst_dbz", 32'(ifc.div_by_zero), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk);
      #1;
      check("no_done_after_rst", 32'(ifc.done), 32'd0);
    end
    run_div("after_rst", 6, 4);

    for (int unsigned n = 0; n <= MAXV; n++) begin
      for (int unsigned d = 0; d <= MAXV; d++) begin
        run_div("exh", n, d);
      end
    end

    for (int i = 0; i < 40; i++) begin
      run_div("rnd", $urandom_range(0, MAXV), $urandom_range(0, MAXV));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 Parameter: W, default 3, operand width in bits; W >= 2 SHALL be supported.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin a division; sampled on the rising edge of clk.
REQ-005 dividend  input  W  unsigned dividend N; sampled only when start is accepted.
REQ-006 divisor  input  W  unsigned divisor D; sampled only when start is accepted.
REQ-007 busy  output  1  high while a division is in progress and start is not accepted.
REQ-008 done  output  1  one-cycle pulse; result outputs are valid in this cycle.
REQ-009 quotient  output  W  unsigned quotient N / D.
REQ-010 remainder  output  W  unsigned remainder N mod D.
REQ-011 div_by_zero  output  1  high with done when D was 0; held until the next accepted start.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 Accept: start=1 in IDLE or DONE latches N and D, clears the quotient, clears the partial remainder, and loads bit counter = W-1.
REQ-014 On accept with D != 0, the next state SHALL be RUN; with D == 0, the next state SHALL be DONE, RUN SHALL be skipped, and div_by_zero SHALL be set.
REQ-015 RUN step (one per cycle, MSB first): P = {R, N[i]} is (W+1) bits wide, and T = P - {0, D} is computed by the subtractor.
REQ-016 The subtractor SHALL compute P + ~{0, D} + 1, with carry-in tied to 1; carry-out 1 means no borrow (P >= D).
REQ-017 If carry-out = 1: R <= T[W-1:0] and quotient bit i <= 1. If carry-out = 0: R <= P[W-1:0] (restore) and quotient bit i <= 0.
REQ-018 RUN SHALL last exactly W cycles; after the step with counter = 0, the next state SHALL be DONE.
REQ-019 Latency: done SHALL be high exactly W+1 rising edges after the accepting edge (normal case), or 1 edge after it (D == 0).
REQ-020 done SHALL be 1 only in DONE, for exactly one cycle; the FSM SHALL return to IDLE unless start=1 in DONE (back-to-back accept).
REQ-021 busy SHALL be 1 only in RUN.
REQ-022 start while in RUN SHALL be ignored; the operand inputs SHALL NOT affect an in-flight division.
REQ-023 quotient, remainder and div_by_zero SHALL be registered and held stable from done until the next accept.
REQ-024 At accept, quotient and remainder SHALL clear to 0.
REQ-025 Divide-by-zero result: quotient = all ones, remainder = N.
REQ-026 With D != 0, the result SHALL satisfy N = quotient*D + remainder and remainder < D, for all 2^(2W) operand pairs.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for clk, force: state = IDLE, busy = 0, done = 0, quotient = 0, remainder = 0, div_by_zero = 0, counter = 0, and latched operands = 0.
REQ-028 Reset asserted mid-RUN SHALL abort the division; no done pulse SHALL follow.
REQ-029 After rst_n rises, the first accept SHALL be possible on the first clk edge.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default width constant.
REQ-031 The (W+1)-bit subtract SHALL be one combinational sub-module, rc_subtractor_w: a ripple of full-subtractor cells, parameter W+1, with ports A, B, CI, S, CO.
REQ-032 The controller SHALL contain all state; the sub-module SHALL contain no registers.

Verification (W=3)
REQ-033 Normal: N=6, D=1 -> done after 4 edges; quotient=6, remainder=0, div_by_zero=0.
REQ-034 Normal: N=5, D=3 -> quotient=1, remainder=2; N=4, D=6 -> quotient=0, remainder=4; N=7, D=7 -> quotient=1, remainder=0.
REQ-035 Divide by zero: N=7, D=0 -> done 1 edge after accept; quotient=7, remainder=7, div_by_zero=1; busy never 1.
REQ-036 Protocol: start held during RUN with new operands -> ignored, first result unchanged; start=1 in the DONE cycle -> new division accepted, busy high next cycle.
REQ-037 Reset mid-op: rst_n low 2 cycles after accept -> all outputs 0 asynchronously, no done; next division N=6, D=4 -> quotient=1, remainder=2.
REQ-038 Exhaustive: all 64 operand pairs checked against the REQ-026 and REQ-025 reference model.
